// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with occupancy count, overflow/underflow pulses and replace-top on push+pop.
// Optional Almost_Full/Almost_Empty outputs are enabled by defining LIFO_STACK_ALMOST_FLAGS_EN.
module lifo_stack_param #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8
`ifdef LIFO_STACK_ALMOST_FLAGS_EN
    ,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
`endif
) (
    input  logic                           Clk,
    input  logic                           RstN,
    input  logic                           Push,
    input  logic                           Pop,
    input  logic [DATA_W-1:0]              Data_In,
    output logic [DATA_W-1:0]              Data_Out,
    output logic                           Full,
    output logic                           Empty,
    output logic [$clog2(DEPTH+1)-1:0]     Count,
    output logic                           Overflow,
    output logic                           Underflow
`ifdef LIFO_STACK_ALMOST_FLAGS_EN
    ,
    output logic                           Almost_Full,
    output logic                           Almost_Empty
`endif
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [ADDR_W-1:0] top_addr_c;

    // Next-state: push/pop/replace-top decisions and error pulses
    always_comb begin
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en_c     = 1'b0;
        wr_addr_c   = ADDR_W'(count_q);
        top_addr_c  = ADDR_W'(count_q - CNT_W'(1));

        case ({Push, Pop})
            2'b10: begin
                if (full_q) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en_c = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (empty_q) begin
                    underflow_d = 1'b1;
                end else begin
                    data_out_d = mem_q[top_addr_c];
                    count_d    = count_q - CNT_W'(1);
                end
            end
            2'b11: begin
                // Empty stack passes the incoming word straight through
                if (empty_q) begin
                    data_out_d = Data_In;
                end else begin
                    data_out_d = mem_q[top_addr_c];
                    wr_en_c    = 1'b1;
                    wr_addr_c  = top_addr_c;
                end
            end
            default: ;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    // Storage needs no reset; only entries below Count are ever read
    always_ff @(posedge Clk) begin
        if (wr_en_c) begin
            mem_q[wr_addr_c] <= Data_In;
        end
    end

    assign Data_Out  = data_out_q;
    assign Full      = full_q;
    assign Empty     = empty_q;
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

`ifdef LIFO_STACK_ALMOST_FLAGS_EN
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;

    always_comb begin
        almost_full_d  = (count_d >= CNT_W'(AF_LEVEL));
        almost_empty_d = (count_d <= CNT_W'(AE_LEVEL));
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign Almost_Full  = almost_full_q;
    assign Almost_Empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param: directed plan scenarios plus randomized traffic against a queue model.
module tb_lifo_stack_param;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              Clk;
    logic              RstN;
    logic              Push;
    logic              Pop;
    logic [DATA_W-1:0] Data_In;
    logic [DATA_W-1:0] Data_Out;
    logic              Full;
    logic              Empty;
    logic [CNT_W-1:0]  Count;
    logic              Overflow;
    logic              Underflow;
`ifdef LIFO_STACK_ALMOST_FLAGS_EN
    logic              Almost_Full;
    logic              Almost_Empty;
`endif

    int checks   = 0;
    int failures = 0;

    int          model_q[$];
    logic [3:0]  exp_dout;
    logic        exp_ovf;
    logic        exp_unf;

    lifo_stack_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .Push      (Push),
        .Pop       (Pop),
        .Data_In   (Data_In),
        .Data_Out  (Data_Out),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow)
`ifdef LIFO_STACK_ALMOST_FLAGS_EN
        ,
        .Almost_Full  (Almost_Full),
        .Almost_Empty (Almost_Empty)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clock of stimulus; the queue model follows the stack's rules, outputs sampled 1ns after the edge
    task automatic cycle(input logic p, input logic q, input logic [3:0] d);
        @(negedge Clk);
        Push = p; Pop = q; Data_In = d;
        @(posedge Clk);
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        if (p && !q) begin
            if (model_q.size() == DEPTH) exp_ovf = 1'b1;
            else model_q.push_back(int'(d));
        end else if (!p && q) begin
            if (model_q.size() == 0) exp_unf = 1'b1;
            else exp_dout = 4'(model_q.pop_back());
        end else if (p && q) begin
            if (model_q.size() == 0) exp_dout = d;
            else begin
                exp_dout = 4'(model_q[model_q.size() - 1]);
                model_q[model_q.size() - 1] = int'(d);
            end
        end
        #1;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout = 4'd0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic test_reset();
        Push = 1'b0; Pop = 1'b0; Data_In = '0;
        RstN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        checks++; if (Count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        checks++; if (Data_Out !== 4'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", Data_Out); end
        checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", Empty, Full); end
        checks++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin failures++; $display("FAIL reset_err got ovf=%0b unf=%0b exp 0 0", Overflow, Underflow); end
`ifdef LIFO_STACK_ALMOST_FLAGS_EN
        checks++; if (Almost_Full !== 1'b0 || Almost_Empty !== 1'b1) begin failures++; $display("FAIL reset_almost got af=%0b ae=%0b exp af=0 ae=1", Almost_Full, Almost_Empty); end
`endif
        @(negedge Clk);
        RstN = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 4'(i + 2));
            checks++; if (Count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", Count, i + 1); end
            checks++; if (Empty !== 1'b0 || Overflow !== 1'b0) begin failures++; $display("FAIL fill_flags got empty=%0b ovf=%0b exp 0 0", Empty, Overflow); end
            checks++; if (Full !== (i == 7)) begin failures++; $display("FAIL fill_full got=%0b exp=%0b", Full, (i == 7)); end
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 4'd10);
        checks++; if (Overflow !== 1'b1 || Count !== 4'd8) begin failures++; $display("FAIL ovf_pulse got ovf=%0b count=%0d exp ovf=1 count=8", Overflow, Count); end
        cycle(1'b0, 1'b0, 4'd0);
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", Overflow); end
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Data_Out !== 4'd9 || Count !== 4'd7) begin failures++; $display("FAIL ovf_pop got dout=%0d count=%0d exp dout=9 count=7", Data_Out, Count); end
    endtask

    task automatic test_drain_underflow();
        cycle(1'b1, 1'b0, 4'd9);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 4'd0);
            checks++; if (Data_Out !== 4'(9 - i) || Count !== 4'(7 - i)) begin failures++; $display("FAIL drain got dout=%0d count=%0d exp dout=%0d count=%0d", Data_Out, Count, 9 - i, 7 - i); end
        end
        checks++; if (Empty !== 1'b1 || Underflow !== 1'b0) begin failures++; $display("FAIL drain_empty got empty=%0b unf=%0b exp 1 0", Empty, Underflow); end
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Underflow !== 1'b1 || Data_Out !== 4'd2 || Overflow !== 1'b0) begin failures++; $display("FAIL unf_pulse got unf=%0b dout=%0d ovf=%0b exp unf=1 dout=2 ovf=0", Underflow, Data_Out, Overflow); end
        cycle(1'b0, 1'b0, 4'd0);
        checks++; if (Underflow !== 1'b0 || Data_Out !== 4'd2 || Count !== 4'd0) begin failures++; $display("FAIL unf_clear got unf=%0b dout=%0d count=%0d exp 0 2 0", Underflow, Data_Out, Count); end
    endtask

    task automatic test_push_pop();
        cycle(1'b1, 1'b0, 4'd2);
        cycle(1'b1, 1'b0, 4'd3);
        cycle(1'b1, 1'b0, 4'd4);
        cycle(1'b1, 1'b1, 4'd7);
        checks++; if (Data_Out !== 4'd4 || Count !== 4'd3) begin failures++; $display("FAIL pp_replace got dout=%0d count=%0d exp dout=4 count=3", Data_Out, Count); end
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Data_Out !== 4'd7) begin failures++; $display("FAIL pp_newtop got=%0d exp=7", Data_Out); end
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Data_Out !== 4'd2 || Empty !== 1'b1) begin failures++; $display("FAIL pp_drain got dout=%0d empty=%0b exp dout=2 empty=1", Data_Out, Empty); end
        cycle(1'b1, 1'b1, 4'd5);
        checks++; if (Data_Out !== 4'd5 || Count !== 4'd0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin failures++; $display("FAIL pp_passthru got dout=%0d count=%0d ovf=%0b unf=%0b exp 5 0 0 0", Data_Out, Count, Overflow, Underflow); end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'(i + 8));
        cycle(1'b1, 1'b1, 4'd1);
        checks++; if (Overflow !== 1'b0 || Count !== 4'd8 || Data_Out !== 4'd15 || Full !== 1'b1) begin failures++; $display("FAIL pp_full got ovf=%0b count=%0d dout=%0d full=%0b exp 0 8 15 1", Overflow, Count, Data_Out, Full); end
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Data_Out !== 4'd1) begin failures++; $display("FAIL pp_full_top got=%0d exp=1", Data_Out); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Count !== 4'd5) begin failures++; $display("FAIL mid_pre got=%0d exp=5", Count); end
        @(negedge Clk);
        Push = 1'b0; Pop = 1'b0;
        #2 RstN = 1'b0;
        #1;
        model_reset();
        checks++; if (Count !== 4'd0 || Empty !== 1'b1 || Data_Out !== 4'd0 || Full !== 1'b0) begin failures++; $display("FAIL mid_async got count=%0d empty=%0b dout=%0d full=%0b exp 0 1 0 0", Count, Empty, Data_Out, Full); end
        @(negedge Clk);
        RstN = 1'b1;
        cycle(1'b1, 1'b0, 4'd6);
        checks++; if (Count !== 4'd1) begin failures++; $display("FAIL mid_push got=%0d exp=1", Count); end
        cycle(1'b0, 1'b1, 4'd0);
        checks++; if (Data_Out !== 4'd6 || Empty !== 1'b1) begin failures++; $display("FAIL mid_pop got dout=%0d empty=%0b exp 6 1", Data_Out, Empty); end
    endtask

`ifdef LIFO_STACK_ALMOST_FLAGS_EN
    task automatic test_almost_flags();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 4'(i));
            checks++; if (Almost_Full !== (i + 1 >= 7) || Almost_Empty !== (i + 1 <= 1)) begin failures++; $display("FAIL almost_up count=%0d got af=%0b ae=%0b", i + 1, Almost_Full, Almost_Empty); end
        end
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b0, 1'b1, 4'd0);
            checks++; if (Almost_Full !== (i >= 7) || Almost_Empty !== (i <= 1)) begin failures++; $display("FAIL almost_down count=%0d got af=%0b ae=%0b", i, Almost_Full, Almost_Empty); end
        end
    endtask
`endif

    // Random traffic with alternating push-heavy and pop-heavy phases so both boundaries are hit repeatedly
    task automatic test_random();
        logic p, q;
        logic [3:0] d;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (((i / 40) % 2) == 0) begin
                p = (r < 6) || (r == 9);
                q = (r >= 6);
            end else begin
                p = (r < 3) || (r == 9);
                q = (r >= 3);
            end
            if (r == 8) begin p = 1'b0; q = 1'b0; end
            d = 4'($urandom_range(0, 15));
            cycle(p, q, d);
            checks++; if (Count !== CNT_W'(model_q.size())) begin failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, Count, model_q.size()); end
            checks++; if (Data_Out !== exp_dout) begin failures++; $display("FAIL rnd_dout i=%0d got=%0d exp=%0d", i, Data_Out, exp_dout); end
            checks++; if (Full !== (model_q.size() == DEPTH) || Empty !== (model_q.size() == 0)) begin failures++; $display("FAIL rnd_flags i=%0d got full=%0b empty=%0b size=%0d", i, Full, Empty, model_q.size()); end
            checks++; if (Overflow !== exp_ovf || Underflow !== exp_unf) begin failures++; $display("FAIL rnd_err i=%0d got ovf=%0b unf=%0b exp ovf=%0b unf=%0b", i, Overflow, Underflow, exp_ovf, exp_unf); end
        end
    endtask

    initial begin
        Push = 1'b0; Pop = 1'b0; Data_In = '0; RstN = 1'b1;
        model_reset();
        #2;
        test_reset();
        test_fill();
        test_overflow();
        test_drain_underflow();
        test_push_pop();
        test_reset_mid();
`ifdef LIFO_STACK_ALMOST_FLAGS_EN
        test_almost_flags();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
Parametrised successor to the team's fixed 4-bit stack. It is a synchronous LIFO buffer with configurable data width and depth. It adds an occupancy count, overflow and underflow error pulses, and a defined simultaneous push/pop (replace-top) mode. It sits between a producer and a consumer in the same clock domain and replaces the fixed stack in new designs.

Parameters:
DATA_W, 4, width of each stored word in bits (>= 1)
DEPTH, 8, number of storage entries (>= 2; need not be a power of two)
CNT_W, $clog2(DEPTH+1), width of Count (derived localparam, not overridable)

Ports:
Clk  input  1  clock; all state updates on rising edge
RstN  input  1  asynchronous, active-low reset
Push  input  1  write request, sampled on rising Clk
Pop  input  1  read request, sampled on rising Clk
Data_In  input  DATA_W  word to push
Data_Out  output  DATA_W  registered output; last popped word
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Count  output  CNT_W  number of valid entries, 0..DEPTH
Overflow  output  1  one-cycle pulse when a push is rejected
Underflow  output  1  one-cycle pulse when a pop is rejected

Behaviour:
- Reset (RstN low, asynchronous assert): Count=0, Data_Out=0, Overflow=0, Underflow=0, so Empty=1 and Full=0. Storage contents are don't-care. Reset may be asserted mid-operation; the stack is empty on the first edge after release.
- Storage: array of DEPTH words. Pointer sp equals Count; the top entry is index Count-1.
- Full and Empty decode from the registered Count, so they change in the same cycle as Count.
- Push only (Push=1, Pop=0):
  - Not Full: mem[Count] <= Data_In and Count increments.
  - Full: no state change and Overflow=1 for one cycle.
- Pop only (Push=0, Pop=1):
  - Not Empty: Data_Out <= mem[Count-1] and Count decrements. Latency is 1 cycle, so the value is visible after the pop edge.
  - Empty: Data_Out holds and Underflow=1 for one cycle.
- Push and Pop together:
  - Not Empty (including Full): Data_Out <= mem[Count-1], then mem[Count-1] <= Data_In. Count is unchanged and no error is raised.
  - Empty: pass-through. Data_Out <= Data_In, Count stays 0, no error.
- Neither asserted: all state holds. Data_Out keeps its last value indefinitely.
- Overflow and Underflow are registered. They are high only in the cycle after the offending edge and clear on the next edge unless the violation repeats. They are never both high.
- Count never exceeds DEPTH and never wraps below 0.
- Data_In is don't-care when Push=0.

Optional Feature:
Macro: LIFO_STACK_ALMOST_FLAGS_EN
- Defined:
  - Adds parameter AF_LEVEL (default DEPTH-1) and AE_LEVEL (default 1).
  - Adds output Almost_Full (Count >= AF_LEVEL) and output Almost_Empty (Count <= AE_LEVEL).
  - Both decode from registered Count.
  - Reset values: Almost_Full=0, Almost_Empty=1.
- Undefined: those parameters and ports do not exist. Core behaviour is identical in both builds.

Test Plan:
1. Reset then fill (DATA_W=4, DEPTH=8): RstN low 1 cycle, then release; push 2,3,...,9 on 8 edges -> Count steps 1..8; Full=1 after the 8th edge; Empty=0 after the 1st edge; no Overflow.
2. Overflow: from full, push 10 -> Overflow=1 for exactly one cycle; Count stays 8. A following pop returns 9 (10 was not stored).
3. Drain and underflow: pop 8 times -> Data_Out sequence 9,8,...,2, one per cycle; Empty=1 after the last pop. A 9th pop -> Underflow=1 for one cycle and Data_Out holds 2.
4. Simultaneous push/pop: with 3 entries pushed (2,3,4), assert Push+Pop with Data_In=7 -> Data_Out=4 and Count stays 3. A following pop returns 7. When Empty, Push+Pop with Data_In=5 -> Data_Out=5, Count=0, no error flags. When Full, Push+Pop -> no Overflow.
5. Reset mid-operation: with Count=5, pull RstN low between edges -> Count=0, Empty=1, Data_Out=0 immediately, without waiting for a clock edge. After release, a push of 6 followed by a pop returns 6.
6. Optional flags (macro defined, defaults): Almost_Full rises when Count reaches 7 and Almost_Empty is high for Count <= 1. Rebuild without the macro and confirm test 1 passes unchanged.
